// File: rtl/afoote_w5s8_tt02_top.sv
// rtl/afoote_w5s8_tt02_top.sv - 5-state 8-symbol Turing machine transition core, TT02 pinout
// Define OUTPUT_REG_EN to register io_out (1-cycle latency, async clear to 0x00).
module afoote_w5s8_tt02_top (
  input  logic [7:0] io_in,
  input  logic       rst_n,
  output logic [7:0] io_out
);
  localparam logic R = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       mode;
  logic [2:0] state_in;
  logic [2:0] sym_in;
  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [2:0] s_eff;
  logic [6:0] entry;
  logic       halt;
  logic [7:0] out_d;

  assign clk      = io_in[0];
  assign state_in = io_in[3:1];
  assign sym_in   = io_in[6:4];
  assign mode     = io_in[7];

  assign s_eff = mode ? state_q : state_in;
  assign halt  = (s_eff > 3'd4);

  // entry = {sym_out, dir_out, state_out}; case key is {state, symbol} in octal
  always_comb begin
    entry = {sym_in, L, s_eff};
    case ({s_eff, sym_in})
      6'o00: entry = {3'd1, R, 3'd0};
      6'o01: entry = {3'd2, R, 3'd0};
      6'o02: entry = {3'd3, L, 3'd1};
      6'o03: entry = {3'd4, R, 3'd2};
      6'o04: entry = {3'd5, L, 3'd0};
      6'o05: entry = {3'd6, R, 3'd3};
      6'o06: entry = {3'd7, L, 3'd4};
      6'o07: entry = {3'd0, R, 3'd0};
      6'o10: entry = {3'd0, L, 3'd1};
      6'o11: entry = {3'd3, R, 3'd2};
      6'o12: entry = {3'd1, L, 3'd0};
      6'o13: entry = {3'd2, R, 3'd1};
      6'o14: entry = {3'd6, L, 3'd3};
      6'o15: entry = {3'd4, R, 3'd4};
      6'o16: entry = {3'd5, L, 3'd1};
      6'o17: entry = {3'd7, R, 3'd2};
      6'o20: entry = {3'd4, L, 3'd2};
      6'o21: entry = {3'd0, R, 3'd3};
      6'o22: entry = {3'd5, R, 3'd1};
      6'o23: entry = {3'd1, L, 3'd4};
      6'o24: entry = {3'd2, R, 3'd0};
      6'o25: entry = {3'd7, L, 3'd2};
      6'o26: entry = {3'd3, R, 3'd3};
      6'o27: entry = {3'd6, L, 3'd0};
      6'o30: entry = {3'd2, R, 3'd3};
      6'o31: entry = {3'd6, L, 3'd4};
      6'o32: entry = {3'd0, L, 3'd2};
      6'o33: entry = {3'd5, R, 3'd0};
      6'o34: entry = {3'd7, R, 3'd1};
      6'o35: entry = {3'd1, L, 3'd3};
      6'o36: entry = {3'd4, L, 3'd0};
      6'o37: entry = {3'd3, R, 3'd4};
      6'o40: entry = {3'd7, L, 3'd0};
      6'o41: entry = {3'd5, R, 3'd1};
      6'o42: entry = {3'd6, R, 3'd3};
      6'o43: entry = {3'd0, L, 3'd2};
      6'o44: entry = {3'd3, L, 3'd4};
      6'o45: entry = {3'd2, R, 3'd2};
      6'o46: entry = {3'd1, R, 3'd0};
      6'o47: entry = {3'd4, L, 3'd1};
      // Halt states 5..7 echo the symbol, move left and keep the state.
      default: entry = {sym_in, L, s_eff};
    endcase
  end

  assign out_d = {entry[2:0], entry[6:4], entry[3], halt};

  always_comb begin
    state_d = state_q;
    if (!mode) begin
      state_d = state_in;
    end else if (!halt) begin
      state_d = entry[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 3'd0;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef OUTPUT_REG_EN
  logic [7:0] out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 8'h00;
    end else begin
      out_q <= out_d;
    end
  end

  assign io_out = out_q;
`else
  assign io_out = out_d;
`endif

endmodule

// File: tb/tb_afoote_w5s8_tt02_top.sv
// tb/tb_afoote_w5s8_tt02_top.sv - randomized self-checking bench for afoote_w5s8_tt02_top
module tb_afoote_w5s8_tt02_top;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode  = 1'b0;
  logic [2:0] st_in = 3'd0;
  logic [2:0] sym   = 3'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int n_vec = 0;
  int n_bad = 0;
  int model_st = 0;

  // Transition table as written: <write><dir><next>, columns symbol 0..7
  string rows [0:4] = '{
    "1R0 2R0 3L1 4R2 5L0 6R3 7L4 0R0",
    "0L1 3R2 1L0 2R1 6L3 4R4 5L1 7R2",
    "4L2 0R3 5R1 1L4 2R0 7L2 3R3 6L0",
    "2R3 6L4 0L2 5R0 7R1 1L3 4L0 3R4",
    "7L0 5R1 6R3 0L2 3L4 2R2 1R0 4L1"
  };

  assign io_in = {mode, sym, st_in, clk};

  always #5 clk = ~clk;

  afoote_w5s8_tt02_top dut (
    .io_in  (io_in),
    .rst_n  (rst_n),
    .io_out (io_out)
  );

  function automatic int model_next(int s, int y);
    if (s > 4) return s;
    return int'(rows[s].getc(y * 4 + 2)) - 48;
  endfunction

  function automatic int model_out(int s, int y);
    int w;
    int d;
    if (s > 4) return s * 32 + y * 4 + 1;
    w = int'(rows[s].getc(y * 4)) - 48;
    d = (int'(rows[s].getc(y * 4 + 1)) == 82) ? 1 : 0;
    return model_next(s, y) * 32 + w * 4 + d * 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_st <= 0;
    else if (!mode) model_st <= int'(st_in);
    else model_st <= model_next(model_st, int'(sym));
  end

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: io_out=0x%02h expected 0x%02h (mode=%0d state_in=%0d sym=%0d)",
               tag, got, exp, mode, st_in, sym);
    end
  endtask

  // Apply one input vector at the falling edge; negative expv means "ask the model".
  task automatic vec(string tag, logic m, int s, int y, int expv);
    int e;
    @(negedge clk);
    mode  = m;
    st_in = 3'(s);
    sym   = 3'(y);
    #1;
    e = expv;
    if (e < 0) e = model_out(m ? model_st : s, y);
    check(tag, io_out, 8'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

`ifdef OUTPUT_REG_EN
  initial begin
    int pend;
    rst_n = 1'b0; mode = 1'b0; st_in = 3'd0; sym = 3'd0;
    #1 check("oreg_rst", io_out, 8'h00);
    rst_n = 1'b1;
    #1 check("oreg_pre_edge", io_out, 8'h00);
    @(posedge clk);
    #1 check("oreg_post_edge", io_out, 8'h06);
    rst_n = 1'b0;
    #1 check("oreg_async_rst", io_out, 8'h00);
    rst_n = 1'b1;
    pend = -1;
    repeat (150) begin
      @(negedge clk);
      #1;
      if (pend >= 0) check("oreg_rand", io_out, 8'(pend));
      mode  = ($urandom_range(0, 3) != 0);
      st_in = 3'($urandom_range(0, 7));
      sym   = 3'($urandom_range(0, 7));
      #1;
      pend = model_out(mode ? model_st : int'(st_in), int'(sym));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
`else
  initial begin
    int hs [4] = '{5, 2, 0, 5};
    int he [4] = '{'hF5, 'hE9, 'hE1, 'hF5};

    rst_n = 1'b0; mode = 1'b1; st_in = 3'd5; sym = 3'd0;
    #1 check("rst_run_s0", io_out, 8'h06);
    mode = 1'b0; st_in = 3'd2;
    #1 check("rst_lookup", io_out, 8'h50);
    rst_n = 1'b1;

    vec("lookup_0_0", 0, 0, 0, 'h06);
    vec("lookup_3_5", 0, 3, 5, 'h64);
    vec("lookup_halt_6_2", 0, 6, 2, 'hC9);
    for (int s = 0; s < 8; s++)
      for (int y = 0; y < 8; y++)
        vec("sweep", 0, s, y, -1);

    @(negedge clk);
    rst_n = 1'b0; mode = 1'b1; sym = 3'd3;
    #1 check("run_s0_sym3", io_out, 8'h52);
    rst_n = 1'b1;
    vec("run_s2_sym1", 1, 0, 1, 'h62);
    vec("run_s3_sym0", 1, 0, 0, 'h6A);

    vec("preload4", 0, 4, 0, 'h1C);
    vec("run_s4_sym0", 1, 0, 0, 'h1C);
    vec("preload7", 0, 7, 5, 'hF5);
    for (int i = 0; i < 4; i++)
      vec("halt_hold", 1, 0, hs[i], he[i]);

    vec("preload3", 0, 3, 0, -1);
    vec("run_s3_pre_rst", 1, 0, 0, 'h6A);
    #1 rst_n = 1'b0;
    #1 check("async_rst", io_out, 8'h06);
    #1 rst_n = 1'b1;

    repeat (300) begin
      vec("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7), -1);
      if ($urandom_range(0, 24) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rand_rst", io_out, 8'(model_out(mode ? 0 : int'(st_in), int'(sym))));
        #1 rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
`endif

endmodule
